// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write port, read ports, scoreboard set port and status.
interface regfile_mp_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned NREAD = 2
);
   localparam int unsigned AW = $clog2(NREGS);

   logic                  we;
   logic [AW-1:0]         wrAddr;
   logic [XLEN-1:0]       wrData;
   logic [NREAD*AW-1:0]   rdAddr;
   logic [NREAD*XLEN-1:0] rdData;
   logic [NREAD-1:0]      rdBusy;
   logic                  setBusy;
   logic [AW-1:0]         setAddr;
   logic [AW:0]           busyCount;

   // Producer side (decode/writeback)
   modport master (
      output we, wrAddr, wrData, rdAddr, setBusy, setAddr,
      input  rdData, rdBusy, busyCount
   );

   // Register file side
   modport slave (
      input  we, wrAddr, wrData, rdAddr, setBusy, setAddr,
      output rdData, rdBusy, busyCount
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional write bypass, hardwired zero
// register and a pending-write scoreboard with a registered population count.
module regfile_mp #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned NREAD    = 2,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1
) (
   input logic         clk,
   input logic         rst,
   regfile_mp_if.slave bus
);
   localparam int unsigned AW = $clog2(NREGS);
   localparam int unsigned CW = AW + 1;

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;
   logic [CW-1:0]    busy_count_q, busy_count_d;

   logic [AW-1:0]         rd_addr_c [NREAD];
   logic [NREAD*XLEN-1:0] rd_data_c;
   logic [NREAD-1:0]      rd_busy_c;
   logic                  wr_zero_c;
   logic                  set_zero_c;

   // Writes and busy-sets aimed at the hardwired zero register are dropped
   assign wr_zero_c  = (ZERO_REG != 0) && (bus.wrAddr == '0);
   assign set_zero_c = (ZERO_REG != 0) && (bus.setAddr == '0);

   // Unpack per-port read indices
   for (genvar g = 0; g < NREAD; g++) begin : g_rd_addr
      assign rd_addr_c[g] = bus.rdAddr[g*AW +: AW];
   end

   // Next register contents
   always_comb begin
      regs_d = regs_q;
      if (bus.we && !wr_zero_c) begin
         regs_d[bus.wrAddr] = bus.wrData;
      end
   end

   // Next scoreboard: completing write clears, new producer sets (set wins)
   always_comb begin
      busy_d = busy_q;
      if (bus.we) begin
         busy_d[bus.wrAddr] = 1'b0;
      end
      if (bus.setBusy && !set_zero_c) begin
         busy_d[bus.setAddr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         busy_d[0] = 1'b0;
      end
   end

   // Population count of the next scoreboard so the count tracks the bits
   always_comb begin
      busy_count_d = '0;
      for (int i = 0; i < NREGS; i++) begin
         busy_count_d = busy_count_d + CW'(busy_d[i]);
      end
   end

   // State registers with synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!rst) begin
         regs_q       <= '{default: '0};
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         regs_q       <= regs_d;
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

   // Combinational read ports: stored value, then bypass, then zero override
   always_comb begin
      rd_data_c = '0;
      rd_busy_c = '0;
      for (int i = 0; i < NREAD; i++) begin
         rd_data_c[i*XLEN +: XLEN] = regs_q[rd_addr_c[i]];
         rd_busy_c[i]              = busy_q[rd_addr_c[i]];
         if ((BYPASS != 0) && bus.we && (bus.wrAddr == rd_addr_c[i])) begin
            rd_data_c[i*XLEN +: XLEN] = bus.wrData;
            rd_busy_c[i]              = 1'b0;
         end
         if ((ZERO_REG != 0) && (rd_addr_c[i] == '0)) begin
            rd_data_c[i*XLEN +: XLEN] = '0;
            rd_busy_c[i]              = 1'b0;
         end
      end
   end

   assign bus.rdData    = rd_data_c;
   assign bus.rdBusy    = rd_busy_c;
   assign bus.busyCount = busy_count_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a 4-port bypassing instance and a
// 2-port non-bypassing instance share stimulus and one reference model.
module tb_regfile_mp;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned AW    = 5;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(4)) a_if ();
   regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(2)) b_if ();

   assign b_if.we      = a_if.we;
   assign b_if.wrAddr  = a_if.wrAddr;
   assign b_if.wrData  = a_if.wrData;
   assign b_if.rdAddr  = a_if.rdAddr[2*AW-1:0];
   assign b_if.setBusy = a_if.setBusy;
   assign b_if.setAddr = a_if.setAddr;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(4), .BYPASS(1), .ZERO_REG(1))
      dut_a (.clk(clk), .rst(rst), .bus(a_if));
   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(2), .BYPASS(0), .ZERO_REG(1))
      dut_b (.clk(clk), .rst(rst), .bus(b_if));

   always #5 clk = ~clk;

   // Reference model: architectural state as plain arrays
   logic [31:0] m_reg  [NREGS];
   bit          m_busy [NREGS];

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
      return c;
   endfunction

   function automatic logic [31:0] m_rd(input int addr, input bit bypass);
      if (addr == 0) return 32'h0;
      if (bypass && a_if.we && int'(a_if.wrAddr) == addr) return a_if.wrData;
      return m_reg[addr];
   endfunction

   function automatic bit m_bz(input int addr, input bit bypass);
      if (addr == 0) return 1'b0;
      if (bypass && a_if.we && int'(a_if.wrAddr) == addr) return 1'b0;
      return m_busy[addr];
   endfunction

   function automatic int rd_addr(input int p);
      logic [4*AW-1:0] v;
      v = a_if.rdAddr;
      return int'(v[p*AW +: AW]);
   endfunction

   task automatic model_edge();
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (a_if.we && a_if.wrAddr != 0) m_reg[a_if.wrAddr] = a_if.wrData;
         if (a_if.we) m_busy[a_if.wrAddr] = 1'b0;
         if (a_if.setBusy && a_if.setAddr != 0) m_busy[a_if.setAddr] = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input bit w, input int wa, input logic [31:0] wd,
                        input bit sb, input int sa);
      a_if.we      = w;
      a_if.wrAddr  = AW'(wa);
      a_if.wrData  = wd;
      a_if.setBusy = sb;
      a_if.setAddr = AW'(sa);
   endtask

   task automatic set_rd(input int p, input int addr);
      logic [4*AW-1:0] v;
      v = a_if.rdAddr;
      v[p*AW +: AW] = AW'(addr);
      a_if.rdAddr = v;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0);
      a_if.rdAddr = '0;
      tick();
      rst = 1'b1;
      drive(1, 5, 32'hDEADBEEF, 1, 6);
      tick();
      // reset with a write and a set in flight: both discarded
      rst = 1'b0;
      drive(1, 5, 32'h11111111, 1, 5);
      tick();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      set_rd(0, 5); set_rd(1, 6); set_rd(2, 5); set_rd(3, 1);
      #1;
      for (int p = 0; p < 4; p++) begin
         n_checks++;
         if (a_if.rdData[p*32 +: 32] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data p%0d: got %h expected 00000000", p, a_if.rdData[p*32 +: 32]);
         end
      end
      n_checks++;
      if (a_if.rdBusy !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_busy: got %b expected 0000", a_if.rdBusy);
      end
      n_checks++;
      if (a_if.busyCount !== 6'd0 || b_if.busyCount !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_count: got %0d/%0d expected 0", a_if.busyCount, b_if.busyCount);
      end
   endtask

   task automatic test_write_read();
      drive(1, 7, 32'h12345678, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      set_rd(0, 7);
      #1;
      n_checks++;
      if (a_if.rdData[31:0] !== 32'h12345678 || b_if.rdData[31:0] !== 32'h12345678) begin
         n_fail++;
         $display("FAIL write_read_x7: got %h/%h expected 12345678", a_if.rdData[31:0], b_if.rdData[31:0]);
      end
      drive(1, 0, 32'hFFFFFFFF, 0, 0);
      set_rd(0, 0); set_rd(1, 0); set_rd(2, 0); set_rd(3, 0);
      #1;
      n_checks++;
      if (a_if.rdData !== 128'h0) begin
         n_fail++;
         $display("FAIL x0_same_cycle: got %h expected 0", a_if.rdData);
      end
      tick();
      drive(0, 0, 0, 0, 0);
      #1;
      n_checks++;
      if (a_if.rdData !== 128'h0 || b_if.rdData !== 64'h0) begin
         n_fail++;
         $display("FAIL x0_after_write: got %h/%h expected 0", a_if.rdData, b_if.rdData);
      end
   endtask

   task automatic test_bypass();
      drive(1, 3, 32'hA5A5A5A5, 0, 0);
      set_rd(1, 3);
      #1;
      n_checks++;
      if (a_if.rdData[63:32] !== 32'hA5A5A5A5) begin
         n_fail++;
         $display("FAIL bypass_on: got %h expected a5a5a5a5", a_if.rdData[63:32]);
      end
      n_checks++;
      if (b_if.rdData[63:32] !== 32'h0) begin
         n_fail++;
         $display("FAIL bypass_off_before: got %h expected 00000000", b_if.rdData[63:32]);
      end
      tick();
      drive(0, 0, 0, 0, 0);
      #1;
      n_checks++;
      if (b_if.rdData[63:32] !== 32'hA5A5A5A5) begin
         n_fail++;
         $display("FAIL bypass_off_after: got %h expected a5a5a5a5", b_if.rdData[63:32]);
      end
      // busy flag is masked only where data is forwarded
      drive(0, 0, 0, 1, 4);
      tick();
      drive(1, 4, 32'h44, 0, 0);
      set_rd(1, 4);
      #1;
      n_checks++;
      if (a_if.rdBusy[1] !== 1'b0 || b_if.rdBusy[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL bypass_busy: got %b/%b expected 0/1", a_if.rdBusy[1], b_if.rdBusy[1]);
      end
      tick();
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_scoreboard();
      drive(0, 0, 0, 1, 9);
      tick();
      drive(0, 0, 0, 0, 0);
      set_rd(0, 9);
      #1;
      n_checks++;
      if (a_if.rdBusy[0] !== 1'b1 || a_if.busyCount !== 6'd1) begin
         n_fail++;
         $display("FAIL sb_set: got busy=%b count=%0d expected 1/1", a_if.rdBusy[0], a_if.busyCount);
      end
      drive(1, 9, 32'h55, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      #1;
      n_checks++;
      if (a_if.rdBusy[0] !== 1'b0 || a_if.busyCount !== 6'd0 || a_if.rdData[31:0] !== 32'h55) begin
         n_fail++;
         $display("FAIL sb_clear: got busy=%b count=%0d data=%h expected 0/0/55", a_if.rdBusy[0], a_if.busyCount, a_if.rdData[31:0]);
      end
      drive(0, 0, 0, 1, 9);
      tick();
      drive(0, 0, 0, 1, 9);       // set on already-busy register
      tick();
      drive(1, 9, 32'h66, 1, 9);  // completion and new producer together
      tick();
      drive(0, 0, 0, 0, 0);
      #1;
      n_checks++;
      if (b_if.rdBusy[0] !== 1'b1 || a_if.busyCount !== 6'd1) begin
         n_fail++;
         $display("FAIL sb_set_wins: got busy=%b count=%0d expected 1/1", b_if.rdBusy[0], a_if.busyCount);
      end
      drive(0, 0, 0, 1, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      set_rd(2, 0);
      #1;
      n_checks++;
      if (a_if.busyCount !== 6'd1 || a_if.rdBusy[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL sb_x0: got count=%0d busy=%b expected 1/0", a_if.busyCount, a_if.rdBusy[2]);
      end
   endtask

   task automatic test_sweep();
      int q [4];
      logic [31:0] exp;
      for (int i = 1; i < NREGS; i++) begin
         drive(1, i, 32'h100 + 32'(i), 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0);
      for (int n = 0; n < 40; n++) begin
         for (int p = 0; p < 4; p++) begin
            if (p > 0 && $urandom_range(0, 2) == 0) q[p] = q[$urandom_range(0, p-1)];
            else q[p] = int'($urandom_range(0, NREGS-1));
            set_rd(p, q[p]);
         end
         #1;
         for (int p = 0; p < 4; p++) begin
            exp = (q[p] == 0) ? 32'h0 : 32'h100 + 32'(q[p]);
            n_checks++;
            if (a_if.rdData[p*32 +: 32] !== exp) begin
               n_fail++;
               $display("FAIL sweep p%0d x%0d: got %h expected %h", p, q[p], a_if.rdData[p*32 +: 32], exp);
            end
         end
      end
      for (int i = 0; i < NREGS; i++) begin
         drive(0, 0, 0, 1, i);
         tick();
      end
      drive(0, 0, 0, 0, 0);
      set_rd(0, 31); set_rd(1, 1); set_rd(2, 0); set_rd(3, 17);
      #1;
      n_checks++;
      if (a_if.busyCount !== 6'd31 || a_if.rdBusy !== 4'b1011) begin
         n_fail++;
         $display("FAIL sweep_all_busy: got count=%0d busy=%b expected 31/1011", a_if.busyCount, a_if.rdBusy);
      end
   endtask

   task automatic test_random();
      int a;
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 63) != 0);
         drive($urandom_range(0, 1) == 1, int'($urandom_range(0, NREGS-1)), $urandom(),
               $urandom_range(0, 2) == 0, int'($urandom_range(0, NREGS-1)));
         for (int p = 0; p < 4; p++) begin
            if ($urandom_range(0, 3) == 0) set_rd(p, int'(a_if.wrAddr));
            else set_rd(p, int'($urandom_range(0, NREGS-1)));
         end
         #1;
         for (int p = 0; p < 4; p++) begin
            a = rd_addr(p);
            n_checks++;
            if (a_if.rdData[p*32 +: 32] !== m_rd(a, 1'b1) || a_if.rdBusy[p] !== m_bz(a, 1'b1)) begin
               n_fail++;
               $display("FAIL rand_a p%0d x%0d: got %h/%b expected %h/%b", p, a,
                        a_if.rdData[p*32 +: 32], a_if.rdBusy[p], m_rd(a, 1'b1), m_bz(a, 1'b1));
            end
            if (p < 2) begin
               n_checks++;
               if (b_if.rdData[p*32 +: 32] !== m_rd(a, 1'b0) || b_if.rdBusy[p] !== m_bz(a, 1'b0)) begin
                  n_fail++;
                  $display("FAIL rand_b p%0d x%0d: got %h/%b expected %h/%b", p, a,
                           b_if.rdData[p*32 +: 32], b_if.rdBusy[p], m_rd(a, 1'b0), m_bz(a, 1'b0));
               end
            end
         end
         n_checks++;
         if (a_if.busyCount !== 6'(m_count()) || b_if.busyCount !== 6'(m_count())) begin
            n_fail++;
            $display("FAIL rand_count: got %0d/%0d expected %0d", a_if.busyCount, b_if.busyCount, m_count());
         end
         tick();
      end
      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b0;
      a_if.we = 1'b0; a_if.wrAddr = '0; a_if.wrData = '0;
      a_if.setBusy = 1'b0; a_if.setAddr = '0; a_if.rdAddr = '0;
      for (int i = 0; i < NREGS; i++) begin
         m_reg[i] = 32'h0;
         m_busy[i] = 1'b0;
      end
      test_reset();
      test_write_read();
      test_bypass();
      test_scoreboard();
      test_sweep();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the single-cycle/pipelined RV32 datapath; generalises the fixed 32x32, two-read-port unit.
- Adds synchronous clear, optional write-to-read bypass, a hardwired zero register, and a per-register pending-write scoreboard for hazard detection by the decode stage.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of 2, >=2)
NREAD, 2, number of independent read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = read returns old value
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and scoreboard sets
Derived: AW = log2(NREGS)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low
we  in  1  write enable
wrAddr  in  AW  write register index
wrData  in  XLEN  write data
rdAddr  in  NREAD*AW  packed read indices, port i = bits [i*AW +: AW]
rdData  out  NREAD*XLEN  packed read data, port i = bits [i*XLEN +: XLEN]
rdBusy  out  NREAD  1 = register addressed by port i has a pending write
setBusy  in  1  mark register setAddr as pending (long-latency producer issued)
setAddr  in  AW  register index to mark
busyCount  out  AW+1  number of registers currently marked pending

Behaviour:
- Reset: rst low at rising edge -> all registers = 0, all busy bits = 0, busyCount = 0. Reset overrides we and setBusy in the same cycle. Reset asserted mid-operation discards any in-flight write. No other initialisation exists (no file loading).
- Write: at rising edge with rst high and we=1 -> reg[wrAddr] <= wrData. With ZERO_REG=1 and wrAddr=0, the write is dropped.
- Read: combinational, zero latency, per port: rdData[i] = reg[rdAddr[i]].
  - With ZERO_REG=1 and rdAddr[i]=0 -> 0.
  - With BYPASS=1, we=1, wrAddr=rdAddr[i], and the address not the zero register -> rdData[i] = wrData (current-cycle value).
  - With BYPASS=0 -> stored value until the edge.
- Scoreboard: busy[NREGS] bits, updated on the rising edge.
  - we=1 clears busy[wrAddr].
  - setBusy=1 sets busy[setAddr].
  - setBusy and we on the same address in the same cycle -> set wins; the bit ends at 1, since a new producer is issued after the completing one.
  - setBusy on an already-busy register -> stays 1, count unchanged.
  - ZERO_REG=1: setAddr=0 is ignored; busy[0] is always 0.
- rdBusy[i] = busy[rdAddr[i]], combinational.
  - With BYPASS=1, rdBusy[i] is forced to 0 when the same-cycle write matches rdAddr[i], because the data is forwarded.
- busyCount: registered population count of busy bits, consistent with the busy bits after every edge. Range 0..NREGS, or 0..NREGS-1 when ZERO_REG=1. No wrap-around is possible.
- Multiple read ports may address the same register; all return identical data.
- No X propagation: every output is defined from reset onward.

Test Plan:
- Reset clear: write 0xDEADBEEF to x5, assert rst low one cycle -> rdData(x5)=0x00000000, busyCount=0, rdBusy=0.
- Write/read and x0: we=1, wrAddr=7, wrData=0x12345678; next cycle rdAddr0=7 -> 0x12345678. Write 0xFFFFFFFF to x0 -> rdData for x0 remains 0.
- Bypass: BYPASS=1, same cycle we=1 to x3 with 0xA5A5A5A5 and rdAddr1=3 -> rdData1=0xA5A5A5A5 before the edge. Repeat with BYPASS=0 -> old value 0x00000000 until after the edge.
- Scoreboard set/clear: setBusy x9 -> next cycle rdBusy=1, busyCount=1. Write x9 with 0x55 -> next cycle rdBusy=0, busyCount=0.
- Simultaneous set and write to x9 with busy[9]=1 -> busy[9] stays 1 and busyCount is unchanged. setBusy x0 -> busyCount unchanged.
- Multi-port sweep, NREAD=4: fill x1..x31 with value = 0x100+i, read random quads including duplicates -> every port matches the model. Set all 31 busy bits -> busyCount=31.
